// File: rtl/regfile_seq_pkg.sv
// Shared opcodes and sequencer state encoding for the register-file instruction sequencer.
package regfile_seq_pkg;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDI = 3'd1;
    localparam logic [2:0] OP_MOV = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

endpackage

// File: rtl/regfile_alu.sv
// Combinational ALU: result/carry for one register-transfer opcode.
module regfile_alu
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_LDI: result = imm;
            OP_MOV: result = a;
            OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB: begin
                result = a - b;
                carry  = (a < b);
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            default: ;
        endcase
    end

endmodule

// File: rtl/regfile_seq.sv
// Instruction sequencer driving an external register file: accept, read operands, write result.
module regfile_seq
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [ADDR_W-1:0] in_dst,
    input  logic [ADDR_W-1:0] in_srca,
    input  logic [ADDR_W-1:0] in_srcb,
    input  logic [DATA_W-1:0] in_imm,
    output logic [ADDR_W-1:0] AA,
    output logic [ADDR_W-1:0] BA,
    input  logic [DATA_W-1:0] Data_A,
    input  logic [DATA_W-1:0] Data_B,
    output logic [ADDR_W-1:0] DA,
    output logic [DATA_W-1:0] Data_in,
    output logic              WR,
    output logic              done,
    output logic              busy,
    output logic              init_done,
    output logic              flag_z,
    output logic              flag_c
);

    localparam int     NREGS    = 2 ** ADDR_W;
    localparam state_t ST_RESET = (INIT_CLEAR != 0) ? ST_INIT : ST_IDLE;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   sweep_cnt;
    logic [ADDR_W-1:0]   dst_q, srca_q, srcb_q;
    logic [2:0]          op_q;
    logic [DATA_W-1:0]   imm_q, result_q;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_c;
    logic                sweep_last;

    assign sweep_last = (sweep_cnt == ADDR_W'(NREGS - 1));

    regfile_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op_q),
        .a      (Data_A),
        .b      (Data_B),
        .imm    (imm_q),
        .result (alu_res),
        .carry  (alu_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_RESET;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  if (sweep_last) state_nxt = ST_IDLE;
            ST_IDLE:  if (in_valid)   state_nxt = ST_READ;
            ST_READ:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are qualified by rst so a mid-operation reset kills WR in the same instant.
    always_comb begin
        in_ready = 1'b0;
        WR       = 1'b0;
        DA       = '0;
        Data_in  = '0;
        done     = 1'b0;
        busy     = 1'b0;
        if (rst) begin
            case (state)
                ST_INIT: begin
                    WR   = 1'b1;
                    DA   = sweep_cnt;
                    busy = 1'b1;
                end
                ST_IDLE:  in_ready = 1'b1;
                ST_READ:  busy = 1'b1;
                ST_WRITE: begin
                    busy    = 1'b1;
                    done    = 1'b1;
                    WR      = (op_q != OP_NOP);
                    DA      = dst_q;
                    Data_in = result_q;
                end
                default: ;
            endcase
        end
    end

    assign AA = srca_q;
    assign BA = srcb_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sweep_cnt <= '0;
            init_done <= 1'b0;
            op_q      <= OP_NOP;
            dst_q     <= '0;
            srca_q    <= '0;
            srcb_q    <= '0;
            imm_q     <= '0;
            result_q  <= '0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
        end else begin
            if (state == ST_INIT) begin
                sweep_cnt <= sweep_cnt + ADDR_W'(1);
                if (sweep_last) init_done <= 1'b1;
            end
            if (state == ST_IDLE && in_valid) begin
                op_q   <= in_op;
                dst_q  <= in_dst;
                srca_q <= in_srca;
                srcb_q <= in_srcb;
                imm_q  <= in_imm;
            end
            // NOP keeps the previous flags so software can still test them afterwards.
            if (state == ST_READ) begin
                result_q <= alu_res;
                if (op_q != OP_NOP) begin
                    flag_z <= (alu_res == '0);
                    flag_c <= alu_c;
                end
            end
        end
    end

endmodule
